// File: rtl/adder_bist_pkg.sv
// Shared types and helpers for the adder BIST sequencer.
// Vector count depends on ADDER_BIST_CIN_SWEEP_EN (cin swept as vector LSB when defined).
package adder_bist_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Field layout of a vector word {a, b, cin}; a sits above b.
    localparam int unsigned VEC_CIN_BIT = 0;
    localparam int unsigned VEC_B_LSB   = 1;

    function automatic int unsigned vec_a_lsb(input int unsigned width);
        return width + 1;
    endfunction

    function automatic int unsigned vec_count(input int unsigned width);
`ifdef ADDER_BIST_CIN_SWEEP_EN
        return 32'd1 << (2 * width + 1);
`else
        return 32'd1 << (2 * width);
`endif
    endfunction

endpackage

// File: rtl/adder_ref_model.sv
// Combinational golden adder: res_o = {cout, sum} = a + b + cin, full WIDTH+1 bits.
module adder_ref_model #(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH:0]   res_o
);

    always_comb begin
        res_o = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
    end

endmodule

// File: rtl/adder_bist.sv
// Built-in sweep/check sequencer for a combinational adder under test.
// Define ADDER_BIST_CIN_SWEEP_EN to also sweep cin (vector LSB); otherwise cin stays 0.
module adder_bist
    import adder_bist_pkg::*;
#(
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic                 cin,
    input  logic [WIDTH-1:0]     sum,
    input  logic                 cout,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 first_fail_valid,
    output logic [2*WIDTH:0]     first_fail_vec
);

    localparam int unsigned VW    = 2 * WIDTH + 1;
    localparam int unsigned N     = vec_count(WIDTH);
    localparam int unsigned A_LSB = vec_a_lsb(WIDTH);
`ifdef ADDER_BIST_CIN_SWEEP_EN
    localparam int unsigned STEP  = 1;
`else
    localparam int unsigned STEP  = 2;
`endif
    // The vector register is the {a,b,cin} word itself; without cin sweep it advances by 2.
    localparam logic [VW-1:0] STEP_VEC = VW'(STEP);
    localparam logic [VW-1:0] LAST_VEC = VW'((N - 1) * STEP);

    state_e               state_q;
    logic [VW-1:0]        vec_q;
    logic [VW-1:0]        vec_d;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;
    logic [ERR_CNT_W-1:0] err_q;
    logic [ERR_CNT_W-1:0] err_d;
    logic                 ffv_q;
    logic [VW-1:0]        ffvec_q;
    logic [WIDTH:0]       exp_res;
    logic                 mismatch;
    logic                 comparing;

    adder_ref_model #(
        .WIDTH(WIDTH)
    ) u_ref (
        .a_i   (vec_q[A_LSB +: WIDTH]),
        .b_i   (vec_q[VEC_B_LSB +: WIDTH]),
        .cin_i (vec_q[VEC_CIN_BIT]),
        .res_o (exp_res)
    );

    always_comb begin
        vec_d     = vec_q + STEP_VEC;
        comparing = (state_q == S_RUN) || (state_q == S_DRAIN);
        mismatch  = ({cout, sum} != exp_res);
        err_d     = (err_q == '1) ? err_q : err_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
        end else begin
            done_q <= 1'b0;

            // The response on sum/cout belongs to the vector currently held in vec_q.
            if (comparing && mismatch) begin
                err_q <= err_d;
                if (!ffv_q) begin
                    ffv_q   <= 1'b1;
                    ffvec_q <= vec_q;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        vec_q   <= '0;
                        err_q   <= '0;
                        ffv_q   <= 1'b0;
                        ffvec_q <= '0;
                    end
                end
                S_RUN: begin
                    vec_q <= vec_d;
                    if (vec_d == LAST_VEC) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    pass_q  <= !mismatch && (err_q == '0);
                    vec_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign a                = vec_q[A_LSB +: WIDTH];
    assign b                = vec_q[VEC_B_LSB +: WIDTH];
    assign cin              = vec_q[VEC_CIN_BIT];
    assign err_cnt          = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: behavioural adder with selectable faults, scoreboard of vectors and results.
module tb_adder_bist;

    localparam int unsigned W = 2;
`ifdef ADDER_BIST_CIN_SWEEP_EN
    localparam int unsigned N = 32;
`else
    localparam int unsigned N = 16;
`endif

    typedef struct packed {
        logic [7:0] err;
        logic [1:0] err2;
        logic       ffv;
        logic [4:0] ffvec;
        logic       pass;
    } res_t;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;

    logic         busy1, done1, pass1, cin1, cout1, ffv1;
    logic [W-1:0] a1, b1, sum1;
    logic [7:0]   err1;
    logic [4:0]   ffvec1;

    logic         busy2, done2, pass2, cin2, cout2, ffv2;
    logic [W-1:0] a2, b2, sum2;
    logic [1:0]   err2;
    logic [4:0]   ffvec2;

    int           fault_mode = 0;
    int           n_checks   = 0;
    int           n_errors   = 0;
    logic         exp_pass_prev = 1'b0;

    logic [4:0]   vec_sb[$];
    res_t         res_sb[$];

    always #5 clk = ~clk;

    // 0: correct, 1: sum[0] stuck-at-0, 2: cout stuck-at-0, 3: all outputs stuck-at-0
    function automatic logic [W:0] model_adder(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic c, input int mode);
        logic [W:0] r;
        r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        case (mode)
            1:       r[0] = 1'b0;
            2:       r[W] = 1'b0;
            3:       r    = '0;
            default: ;
        endcase
        return r;
    endfunction

    always_comb {cout1, sum1} = model_adder(a1, b1, cin1, fault_mode);
    always_comb {cout2, sum2} = model_adder(a2, b2, cin2, fault_mode);

    adder_bist #(
        .WIDTH     (W),
        .ERR_CNT_W (8)
    ) dut1 (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .busy             (busy1),
        .done             (done1),
        .pass             (pass1),
        .a                (a1),
        .b                (b1),
        .cin              (cin1),
        .sum              (sum1),
        .cout             (cout1),
        .err_cnt          (err1),
        .first_fail_valid (ffv1),
        .first_fail_vec   (ffvec1)
    );

    adder_bist #(
        .WIDTH     (W),
        .ERR_CNT_W (2)
    ) dut2 (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .busy             (busy2),
        .done             (done2),
        .pass             (pass2),
        .a                (a2),
        .b                (b2),
        .cin              (cin2),
        .sum              (sum2),
        .cout             (cout2),
        .err_cnt          (err2),
        .first_fail_valid (ffv2),
        .first_fail_vec   (ffvec2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Vector i of the sweep as {a, b, cin}
    function automatic logic [4:0] vec_of(input int i);
        logic [4:0] v;
`ifdef ADDER_BIST_CIN_SWEEP_EN
        v = 5'(i);
`else
        v = {4'(i), 1'b0};
`endif
        return v;
    endfunction

    task automatic load_scoreboard(input int mode);
        int         cnt;
        logic       fv;
        logic [4:0] fvec;
        logic [4:0] v;
        logic [W:0] good;
        res_t       r;
        cnt  = 0;
        fv   = 1'b0;
        fvec = '0;
        for (int i = 0; i < int'(N); i++) begin
            v    = vec_of(i);
            good = 3'(v[4:3]) + 3'(v[2:1]) + 3'(v[0]);
            vec_sb.push_back(v);
            if (model_adder(v[4:3], v[2:1], v[0], mode) !== good) begin
                cnt++;
                if (!fv) begin
                    fv   = 1'b1;
                    fvec = v;
                end
            end
        end
        r.err   = (cnt > 255) ? 8'd255 : 8'(cnt);
        r.err2  = (cnt > 3) ? 2'd3 : 2'(cnt);
        r.ffv   = fv;
        r.ffvec = fvec;
        r.pass  = (cnt == 0);
        res_sb.push_back(r);
    endtask

    task automatic check_reset_state(input string p);
        check({p, "_busy"},  32'(busy1),  0);
        check({p, "_done"},  32'(done1),  0);
        check({p, "_pass"},  32'(pass1),  0);
        check({p, "_vec"},   32'({a1, b1, cin1}), 0);
        check({p, "_err"},   32'(err1),   0);
        check({p, "_ffv"},   32'(ffv1),   0);
        check({p, "_ffvec"}, 32'(ffvec1), 0);
        check({p, "_err2"},  32'(err2),   0);
    endtask

    // Sweep with scoreboard; pre_started means edge t has already sampled start.
    task automatic run_sweep(input int mode, input bit hold, input bit pre_started);
        res_t       r;
        logic [4:0] ev;
        fault_mode = mode;
        load_scoreboard(mode);
        if (!pre_started) begin
            @(negedge clk);
            start = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!hold) start = 1'b0;
        for (int c = 0; c < int'(N); c++) begin
            if (c == 0) begin
                check("err_cleared", 32'(err1), 0);
                check("ffv_cleared", 32'(ffv1), 0);
            end
            check("busy_run",   32'(busy1), 1);
            check("done_early", 32'(done1), 0);
            check("pass_held_run", 32'(pass1), 32'(exp_pass_prev));
            ev = vec_sb.pop_front();
            check("vector",      32'({a1, b1, cin1}), 32'(ev));
            check("vector_dut2", 32'({a2, b2, cin2}), 32'(ev));
            @(posedge clk);
            #1;
        end
        r = res_sb.pop_front();
        check("done_pulse", 32'(done1), 1);
        check("busy_end",   32'(busy1), 0);
        check("pass",       32'(pass1), 32'(r.pass));
        check("err_cnt",    32'(err1),  32'(r.err));
        check("ffv",        32'(ffv1),  32'(r.ffv));
        check("ffvec",      32'(ffvec1), 32'(r.ffvec));
        check("vec_idle",   32'({a1, b1, cin1}), 0);
        check("done2",      32'(done2), 1);
        check("err_cnt_sat", 32'(err2), 32'(r.err2));
        check("pass2",      32'(pass2), 32'(r.pass));
        exp_pass_prev = r.pass;
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done1), 0);
        check("pass_hold",      32'(pass1), 32'(r.pass));
        check("err_hold",       32'(err1),  32'(r.err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        run_sweep(0, 1'b0, 1'b0);
        run_sweep(1, 1'b0, 1'b0);
        run_sweep(2, 1'b0, 1'b0);
        run_sweep(3, 1'b0, 1'b0);
        run_sweep(0, 1'b0, 1'b0);

        // Reset in the middle of a faulty sweep, after a passing one
        fault_mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("rst_pre_vec5", 32'({a1, b1, cin1}), 32'(vec_of(5)));
        check("rst_pre_ffv",  32'(ffv1), 1);
        #2 rst = 1'b1;
        #1;
        check_reset_state("rst_async");
        @(posedge clk);
        #1;
        check_reset_state("rst_held");
        @(negedge clk);
        rst = 1'b0;
        exp_pass_prev = 1'b0;
        for (int c = 0; c < int'(N) + 4; c++) begin
            @(posedge clk);
            #1;
            check("no_done_after_rst", 32'(done1), 0);
            check("idle_after_rst",    32'(busy1), 0);
        end
        run_sweep(0, 1'b0, 1'b0);

        // start held high: the earliest restart is edge t+N+2
        run_sweep(0, 1'b1, 1'b0);
        check("restart_not_early", 32'(busy1), 0);
        @(posedge clk);
        #1;
        run_sweep(0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adder_bist.md
# adder_bist

Self-checking built-in test sequencer for the 2-bit ripple adder (`adder2bit`) and its wider variants. On a start request it drives every operand combination onto the adder's inputs, one vector per clock. It compares each returned sum and carry against an internal golden model, then reports a pass/fail summary. It sits beside the adder under test and replaces the simulation-only stimulus loop with synthesizable hardware, so the same check runs on silicon/FPGA.

## Interface
- `WIDTH`, default 2: operand width of the adder under test.
- `ERR_CNT_W`, default 8: width of the saturating error counter.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a sweep; honoured only in IDLE.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse at sweep completion.
- `pass` out 1: result of the last sweep (err_cnt==0); held until the next start.
- `a`, `b` out WIDTH: operands to the adder under test (registered).
- `cin` out 1: carry-in to the adder under test (registered).
- `sum` in WIDTH: adder sum response.
- `cout` in 1: adder carry response.
- `err_cnt` out ERR_CNT_W: mismatch count; saturates at all-ones; held after done.
- `first_fail_valid` out 1: at least one mismatch was recorded this sweep.
- `first_fail_vec` out 2*WIDTH+1: {a,b,cin} of the first mismatching vector.

## Operation
- FSM states are IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - a, b and cin are 0.
  - When start=1 at an edge, go to RUN, clear err_cnt, first_fail_valid and first_fail_vec, and register vector 0.
  - pass is not cleared until the DONE edge.
- **RUN:** each edge registers the next vector and compares the response to the previous vector. After registering vector N-1, go to DRAIN.
- **DRAIN:** compares vector N-1, then goes to DONE.
- **DONE:** done=1 and pass updated; the next edge returns to IDLE.
- Vector index order:
  - a is the MSB field, then b, then cin (LSB, only when the sweep macro is enabled).
  - a is the outer loop and b the inner loop, starting from 0.
- Vector count N:
  - 2^(2*WIDTH) without the macro.
  - 2^(2*WIDTH+1) with the macro.
- Golden model: expected {cout,sum} = a + b + cin, computed at WIDTH+1 bits with no truncation.
- The adder under test is combinational. Its response to the registered vector is sampled at the following edge, so compare is valid one cycle after drive.
- Mismatch handling:
  - On a mismatch, err_cnt increments (saturating).
  - If first_fail_valid=0, capture the vector and set first_fail_valid.
- start while busy or in DONE is ignored; it does not queue.
- Reset mid-sweep returns to IDLE with all outputs at reset values. No done pulse is produced.

## Timing
- Reset values: busy=0, done=0, pass=0, a=0, b=0, cin=0, err_cnt=0, first_fail_valid=0, first_fail_vec=0.
- Let edge t be the edge that samples start in IDLE. Then:
  - Vector i appears on a/b/cin in cycle t+i.
  - Vector i is compared at edge t+i+1.
  - busy is high from edge t to edge t+N.
  - done is high in the cycle after edge t+N.
- Start-to-done latency is N edges: 16 for WIDTH=2 without the macro, 32 with it.
- A new sweep can start earliest at edge t+N+2.

## Configuration
- Macro: `ADDER_BIST_CIN_SWEEP_EN`.
- Defined: cin is the LSB of the vector index and toggles every cycle, giving N = 2^(2*WIDTH+1).
- Undefined: cin is constant 0, N = 2^(2*WIDTH), and first_fail_vec[0] always reads 0.

## Structure
- Package `adder_bist_pkg` holds:
  - the FSM state enum;
  - the vector-count function of WIDTH and the macro;
  - the field-offset localparams for {a,b,cin}.
- Sub-module `adder_ref_model` is the combinational golden adder (WIDTH parameter, {cout,sum} output). It is reused later by other checkers.

## Test plan
- **Correct adder2bit, no macro:** one-cycle start. Expected: a/b walk 00/00, 00/01 … 11/11; done 16 edges after start; pass=1; err_cnt=0; first_fail_valid=0.
- **sum[0] stuck-at-0 model:** expected err_cnt=8, first_fail_vec={a=00,b=01,cin=0}, pass=0.
- **cout stuck-at-0 model:** expected err_cnt=6, first_fail_vec={a=01,b=11,cin=0}.
- **Macro defined, correct adder:** expected cin toggles every cycle, done after 32 edges, pass=1.
- **ERR_CNT_W=2 with all-bits-stuck model:** expected err_cnt saturates at 3, pass=0.
- **rst asserted at vector 5:** expected all outputs at reset values immediately and no done pulse. A subsequent start runs the full 16-vector sweep.
- **start held high throughout:** expected extra starts ignored while busy. A new sweep begins at edge t+N+2.
